// File: rtl/data_mem_dumper_pkg.sv
// Shared constants for the data-memory dumper: memory access sizes and FSM encodings.
package data_mem_dumper_pkg;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SET_ADDR = 3'd1;
    localparam logic [2:0] ST_WAIT     = 3'd2;
    localparam logic [2:0] ST_CAPTURE  = 3'd3;
    localparam logic [2:0] ST_SEND     = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/data_mem_dumper.sv
// Sweeps the whole data memory word by word and streams it out LSB-first as bytes
// to the debug UART transmitter. Owns the memory read port while busy.
module data_mem_dumper
    import data_mem_dumper_pkg::*;
#(
    parameter int WORD_LEN      = 32,
    parameter int BYTE_LEN      = 8,
    parameter int DATA_MEM_SIZE = 1024
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    output logic [WORD_LEN-1:0] o_mem_addr,
    output logic [1:0]          o_mem_size,
    output logic                o_mem_unsigned,
    output logic                o_mem_write_en,
    input  logic [WORD_LEN-1:0] i_mem_data,
    output logic [BYTE_LEN-1:0] o_tx_data,
    output logic                o_tx_valid,
    input  logic                i_tx_ready,
    output logic                o_busy,
    output logic                o_done
);

    localparam logic [WORD_LEN-1:0] LAST_ADDR = WORD_LEN'(DATA_MEM_SIZE - BYTES_PER_WORD);
    localparam logic [WORD_LEN-1:0] ADDR_STEP = WORD_LEN'(BYTES_PER_WORD);

    logic [2:0]          state;
    logic [WORD_LEN-1:0] addr;
    logic [WORD_LEN-1:0] word_reg;
    logic [1:0]          byte_idx;
    logic [4:0]          bit_ofs;

    // Port control is static: word-sized unsigned reads only, even during reset.
    assign o_mem_size     = MEM_SIZE_WORD;
    assign o_mem_unsigned = 1'b1;
    assign o_mem_write_en = 1'b0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            addr       <= '0;
            o_mem_addr <= '0;
            word_reg   <= '0;
            byte_idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        addr  <= '0;
                        state <= ST_SET_ADDR;
                    end
                end
                ST_SET_ADDR: begin
                    o_mem_addr <= addr;
                    state      <= ST_WAIT;
                end
                // Memory latches the address on the negedge inside this cycle.
                ST_WAIT: begin
                    state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    word_reg <= i_mem_data;
                    byte_idx <= '0;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (i_tx_ready) begin
                        if (byte_idx != 2'd3) begin
                            byte_idx <= byte_idx + 2'd1;
                        end else if (addr == LAST_ADDR) begin
                            state <= ST_DONE;
                        end else begin
                            addr  <= addr + ADDR_STEP;
                            state <= ST_SET_ADDR;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from registered state, so they are stable all cycle.
    assign bit_ofs    = {byte_idx, 3'b000};
    assign o_tx_data  = word_reg[bit_ofs +: BYTE_LEN];
    assign o_tx_valid = (state == ST_SEND);
    assign o_busy     = (state == ST_SET_ADDR) || (state == ST_WAIT) ||
                        (state == ST_CAPTURE)  || (state == ST_SEND);
    assign o_done     = (state == ST_DONE);

endmodule

// File: tb/tb_data_mem_dumper.sv
// Directed bench for data_mem_dumper: byte stream, handshake stalls, ignored restarts, reset abort.
module tb_data_mem_dumper;

    localparam int MEM = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        mem_we;
    logic [31:0] mem_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    data_mem_dumper #(.WORD_LEN(32), .BYTE_LEN(8), .DATA_MEM_SIZE(MEM)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .o_mem_addr     (mem_addr),
        .o_mem_size     (mem_size),
        .o_mem_unsigned (mem_unsigned),
        .o_mem_write_en (mem_we),
        .i_mem_data     (mem_data),
        .o_tx_data      (tx_data),
        .o_tx_valid     (tx_valid),
        .i_tx_ready     (tx_ready),
        .o_busy         (busy),
        .o_done         (done)
    );

    always #5 clk = ~clk;

    logic [7:0] m [0:MEM-1];

    // Memory samples the address on the negedge.
    always @(negedge clk) begin
        int a;
        a = int'(mem_addr[9:2]) * 4;
        mem_data <= {m[a+3], m[a+2], m[a+1], m[a]};
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int          nbytes, bad_bytes, done_cnt, busy_at_done, bad_step, bad_const;
    int          first_cyc, word1_cyc, done_cyc, stall_bad;
    logic [7:0]  stall_first;
    logic [31:0] max_addr;
    logic        timed_out;
    logic [7:0]  got [0:MEM-1];

    task automatic run_dump(input int stall_at, input int stall_len, input int restart_at,
                            input int stop_at);
        int          stall_cnt;
        logic [31:0] prev_addr;
        nbytes = 0; bad_bytes = 0; done_cnt = 0; busy_at_done = 0; bad_step = 0;
        bad_const = 0; first_cyc = -1; word1_cyc = -1; done_cyc = -1; stall_bad = 0;
        stall_first = 8'h00; max_addr = 0; timed_out = 1'b1; stall_cnt = 0;
        prev_addr = mem_addr;
        for (int cyc = 0; cyc < 9000; cyc++) begin
            @(negedge clk);
            start = (cyc == 0) || (restart_at >= 0 && nbytes == restart_at);
            if (stall_at >= 0 && nbytes == stall_at && stall_cnt < stall_len) begin
                tx_ready = 1'b0;
                if (stall_cnt == 0) stall_first = tx_data;
                else if (tx_data !== stall_first) stall_bad++;
                if (tx_valid !== 1'b1) stall_bad++;
                stall_cnt++;
            end else begin
                tx_ready = 1'b1;
            end
            if (tx_valid && tx_ready) begin
                if (nbytes < MEM) begin
                    got[nbytes] = tx_data;
                    if (tx_data !== m[nbytes]) bad_bytes++;
                end
                if (nbytes == 0) first_cyc = cyc;
                if (nbytes == 4) word1_cyc = cyc;
                nbytes++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (busy) busy_at_done++;
            end
            if (mem_we !== 1'b0 || mem_size !== 2'b10 || mem_unsigned !== 1'b1) bad_const++;
            if (mem_addr != prev_addr && mem_addr != prev_addr + 4 && mem_addr != 0) bad_step++;
            if (mem_addr[1:0] != 2'b00) bad_step++;
            if (mem_addr > max_addr) max_addr = mem_addr;
            prev_addr = mem_addr;
            if (done || (stop_at >= 0 && nbytes == stop_at)) begin
                timed_out = 1'b0;
                break;
            end
        end
        start    = 1'b0;
        tx_ready = 1'b1;
    endtask

    task automatic check_full(input string t, input int exp_done_cyc);
        chk({t, "_timeout"}, 32'(timed_out), 0);
        chk({t, "_nbytes"}, nbytes, MEM);
        chk({t, "_bad_bytes"}, bad_bytes, 0);
        chk({t, "_done_cnt"}, done_cnt, 1);
        chk({t, "_busy_at_done"}, busy_at_done, 0);
        chk({t, "_first_cyc"}, first_cyc, 4);
        chk({t, "_word1_cyc"}, word1_cyc, 11);
        chk({t, "_done_cyc"}, done_cyc, exp_done_cyc);
        chk({t, "_addr_step"}, bad_step, 0);
        chk({t, "_port_const"}, bad_const, 0);
        chk({t, "_max_addr"}, max_addr, 1020);
    endtask

    initial begin
        for (int i = 0; i < MEM; i++) m[i] = 8'((i * 13 + 5) & 255);
        m[0] = 8'h11; m[1] = 8'h22; m[2] = 8'h33; m[3] = 8'h44;
        m[1020] = 8'hDE; m[1021] = 8'hAD; m[1022] = 8'hBE; m[1023] = 8'hEF;

        rst_n = 1'b0; start = 1'b0; tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(tx_valid), 0);
        chk("rst_data", 32'(tx_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_size", 32'(mem_size), 2);
        chk("rst_unsigned", 32'(mem_unsigned), 1);
        chk("rst_we", 32'(mem_we), 0);
        rst_n = 1'b1;

        // Test 1 + 5: clean dump, first and last words
        run_dump(-1, 0, -1, -1);
        check_full("t1", 1793);
        chk("t1_b0", 32'(got[0]), 32'h11);
        chk("t1_b1", 32'(got[1]), 32'h22);
        chk("t1_b2", 32'(got[2]), 32'h33);
        chk("t1_b3", 32'(got[3]), 32'h44);
        chk("t5_b1020", 32'(got[1020]), 32'hDE);
        chk("t5_b1021", 32'(got[1021]), 32'hAD);
        chk("t5_b1022", 32'(got[1022]), 32'hBE);
        chk("t5_b1023", 32'(got[1023]), 32'hEF);

        // Test 2: 10-cycle stall mid-word; start lands on the first IDLE cycle after DONE
        run_dump(5, 10, -1, -1);
        check_full("t2", 1803);
        chk("t2_stall_hold", stall_bad, 0);
        chk("t2_stall_byte", 32'(stall_first), 32'(m[5]));

        // Test 3: start pulsed mid-dump is ignored
        run_dump(-1, 0, 100, -1);
        check_full("t3", 1793);

        // Test 4: reset mid-word aborts, then a fresh dump restarts at address 0
        run_dump(-1, 0, -1, 37);
        chk("t4_reached37", nbytes, 37);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t4_rst_valid", 32'(tx_valid), 0);
        chk("t4_rst_data", 32'(tx_data), 0);
        chk("t4_rst_busy", 32'(busy), 0);
        chk("t4_rst_done", 32'(done), 0);
        chk("t4_rst_addr", mem_addr, 0);
        chk("t4_rst_we", 32'(mem_we), 0);
        rst_n = 1'b1;
        run_dump(-1, 0, -1, -1);
        check_full("t4", 1793);
        chk("t4_b0", 32'(got[0]), 32'h11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
